// File: rtl/scdata_ctr_io_pipe.sv
// rtl/scdata_ctr_io_pipe.sv - L2 data array I/O pipe: request staging, write recovery, read return
//
// Purpose:
//   Accepts one array request per cycle in C2 and registers it onto the array
//   port in C3. Writes force WR_RECOV idle cycles. Reads are tracked through a
//   shift pipeline that is RD_LAT+1 stages deep. Each read returns the full line
//   and the selected column one cycle after the array data arrives (C6).
//
// Ports:
//   rclk, rst                      clock, synchronous active-high reset
//   req_*                          C2 request (valid/ready handshake)
//   st_decc, fbdecc                store data (half column) and fill line
//   arr_*                          C3 array control/write data, arr_decc_out read data
//   rd_vld_c6, rd_decc_c6,
//   rd_line_c6                     read return
//   col_err, col_err_cnt           non-one-hot column pulse and saturating count
module scdata_ctr_io_pipe #(
  parameter int NUM_COLS = 4,
  parameter int COL_W    = 156,
  parameter int WAY_W    = 12,
  parameter int SET_W    = 10,
  parameter int RD_LAT   = 2,
  parameter int WR_RECOV = 1
) (
  input  logic                      rclk,
  input  logic                      rst,
  input  logic                      req_vld,
  output logic                      req_rdy,
  input  logic                      req_rd_wr,
  input  logic                      req_fbrd,
  input  logic                      req_fb_hit,
  input  logic [WAY_W-1:0]          req_way_sel,
  input  logic [SET_W-1:0]          req_set,
  input  logic [NUM_COLS-1:0]       req_col_oh,
  input  logic [4*NUM_COLS-1:0]     req_word_en,
  input  logic [COL_W/2-1:0]        st_decc,
  input  logic [NUM_COLS*COL_W-1:0] fbdecc,
  input  logic [NUM_COLS*COL_W-1:0] arr_decc_out,
  output logic                      arr_vld,
  output logic                      arr_wr_en,
  output logic [WAY_W-1:0]          arr_way_sel,
  output logic [SET_W-1:0]          arr_set,
  output logic [NUM_COLS-1:0]       arr_col_oh,
  output logic [4*NUM_COLS-1:0]     arr_word_en,
  output logic [NUM_COLS*COL_W-1:0] arr_decc_in,
  output logic                      rd_vld_c6,
  output logic [COL_W-1:0]          rd_decc_c6,
  output logic [NUM_COLS*COL_W-1:0] rd_line_c6,
  output logic                      col_err,
  output logic [7:0]                col_err_cnt
);

  localparam int LINE_W = NUM_COLS * COL_W;
  localparam logic [NUM_COLS-1:0] COL_ONE = NUM_COLS'(1);

  logic [1:0]          rcnt;
  logic                accept;
  logic [RD_LAT:0]     p_vld;
  logic [RD_LAT:0]     p_fb;
  logic [NUM_COLS-1:0] p_col [RD_LAT+1];

  logic [LINE_W-1:0]   ret_line;
  logic [NUM_COLS-1:0] ret_col;
  logic                ret_onehot;
  logic [COL_W-1:0]    ret_sel;

  assign req_rdy = ~rst & (rcnt == 2'd0);
  assign accept  = req_vld & req_rdy;

  // Last pipeline stage lines up with the array read data (cycle R).
  assign ret_col    = p_col[RD_LAT];
  assign ret_line   = p_fb[RD_LAT] ? fbdecc : arr_decc_out;
  assign ret_onehot = (ret_col != '0) && ((ret_col & (ret_col - COL_ONE)) == '0);

  always_comb begin
    ret_sel = '0;
    for (int k = 0; k < NUM_COLS; k++) begin
      if (ret_col[k]) ret_sel = ret_sel | ret_line[k*COL_W +: COL_W];
    end
  end

  always_ff @(posedge rclk) begin
    if (rst) begin
      rcnt        <= '0;
      arr_vld     <= 1'b0;
      arr_wr_en   <= 1'b0;
      arr_way_sel <= '0;
      arr_set     <= '0;
      arr_col_oh  <= '0;
      arr_word_en <= '0;
      arr_decc_in <= '0;
      p_vld       <= '0;
      p_fb        <= '0;
      for (int i = 0; i <= RD_LAT; i++) p_col[i] <= '0;
      rd_vld_c6   <= 1'b0;
      rd_decc_c6  <= '0;
      rd_line_c6  <= '0;
      col_err     <= 1'b0;
      col_err_cnt <= '0;
    end else begin
      // Write recovery: reload on an accepted write, otherwise count down.
      if (accept && !req_rd_wr) begin
        rcnt <= 2'(WR_RECOV);
      end else if (rcnt != 2'd0) begin
        rcnt <= rcnt - 2'd1;
      end

      // C3 array port.
      if (accept) begin
        arr_vld     <= 1'b1;
        arr_wr_en   <= ~req_rd_wr;
        arr_way_sel <= req_way_sel;
        arr_set     <= req_set;
        arr_col_oh  <= req_col_oh;
        arr_word_en <= req_word_en;
        if (!req_rd_wr) begin
          arr_decc_in <= req_fbrd ? fbdecc : {(2*NUM_COLS){st_decc}};
        end
      end else begin
        // Set, column and word enables hold to avoid toggling the array address bus.
        arr_vld     <= 1'b0;
        arr_wr_en   <= 1'b0;
        arr_way_sel <= '0;
      end

      // Read tracking pipeline; runs regardless of write recovery.
      p_vld    <= {p_vld[RD_LAT-1:0], accept & req_rd_wr};
      p_fb     <= {p_fb[RD_LAT-1:0], req_fb_hit};
      p_col[0] <= req_col_oh;
      for (int i = 1; i <= RD_LAT; i++) p_col[i] <= p_col[i-1];

      // C6 return.
      rd_vld_c6 <= p_vld[RD_LAT];
      col_err   <= 1'b0;
      if (p_vld[RD_LAT]) begin
        rd_line_c6 <= ret_line;
        if (ret_onehot) begin
          rd_decc_c6 <= ret_sel;
        end else begin
          // Bad column select: keep the last good column, flag and count it.
          col_err <= 1'b1;
          if (col_err_cnt != 8'hff) col_err_cnt <= col_err_cnt + 8'd1;
        end
      end
    end
  end

endmodule
